// File: rtl/scaler_gate_counter.sv
// Gated scaler: counts rising edges per channel over GATE_TICKS khz ticks and
// latches the totals into holding registers with a valid/overrun handshake.
//
// state     | meaning
// WAIT_TICK | counters held at 0, waiting for a start tick
// COUNTING  | gate open, counting edges, latching at every gate end
module scaler_gate_counter #(
  parameter int NCH          = 4,
  parameter int CNT_W        = 16,
  parameter int GATE_TICKS   = 1000,
  parameter int TICK_TIMEOUT = 40000,
  parameter int SEL_W        = 2
) (
  input  logic             clk33_i,
  input  logic             rst_n_i,
  input  logic             khz_clk_i,
  input  logic [NCH-1:0]   hit_i,
  input  logic [SEL_W-1:0] rd_sel_i,
  input  logic             rd_ack_i,
  output logic [CNT_W-1:0] scaler_o,
  output logic             valid_o,
  output logic             overrun_o,
  output logic             tick_stale_o
);

  localparam int TC_W = (GATE_TICKS > 1) ? $clog2(GATE_TICKS) : 1;
  localparam int WD_W = $clog2(TICK_TIMEOUT + 1);
  localparam logic [TC_W-1:0] TC_LAST = TC_W'(GATE_TICKS - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TICK_TIMEOUT);

  typedef enum logic {WAIT_TICK, COUNTING} state_t;

  state_t                    state_q, state_d;
  logic [NCH-1:0]            hit_d_q, hit_rise;
  logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d, cnt_inc, hold_q, hold_d;
  logic [TC_W-1:0]           tick_cnt_q, tick_cnt_d;
  logic [WD_W-1:0]           wdog_q, wdog_d;
  logic                      stale_q, stale_d;
  logic                      valid_q, valid_d;
  logic                      ovr_q, ovr_d;
  logic                      gate_end;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    return (inc && (c != '1)) ? c + 1'b1 : c;
  endfunction

  always_comb begin
    hit_rise = hit_i & ~hit_d_q;
    cnt_inc  = cnt_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_inc[i] = sat_inc(cnt_q[i], hit_rise[i]);
    end
  end

  // Stale is registered from the next watchdog value so it drops the cycle after a tick.
  always_comb begin
    if (khz_clk_i)             wdog_d = '0;
    else if (wdog_q == WD_MAX) wdog_d = wdog_q;
    else                       wdog_d = wdog_q + 1'b1;
    stale_d = (wdog_d == WD_MAX);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    tick_cnt_d = tick_cnt_q;
    gate_end   = 1'b0;
    case (state_q)
      WAIT_TICK: begin
        cnt_d      = '0;
        tick_cnt_d = '0;
        if (khz_clk_i) state_d = COUNTING;
      end
      COUNTING: begin
        if (stale_d) begin
          state_d    = WAIT_TICK;
          cnt_d      = '0;
          tick_cnt_d = '0;
        end else if (khz_clk_i && (tick_cnt_q == TC_LAST)) begin
          gate_end   = 1'b1;
          hold_d     = cnt_inc;
          cnt_d      = '0;
          tick_cnt_d = '0;
        end else begin
          cnt_d = cnt_inc;
          if (khz_clk_i) tick_cnt_d = tick_cnt_q + 1'b1;
        end
      end
      default: state_d = WAIT_TICK;
    endcase
  end

  // A gate end beats a same-cycle ack: the new set stays valid, overrun clears.
  always_comb begin
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (gate_end) begin
      valid_d = 1'b1;
      ovr_d   = valid_q & ~rd_ack_i;
    end else if (rd_ack_i && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk33_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= WAIT_TICK;
      hit_d_q    <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      tick_cnt_q <= '0;
      wdog_q     <= '0;
      stale_q    <= 1'b0;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hit_d_q    <= hit_i;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      tick_cnt_q <= tick_cnt_d;
      wdog_q     <= wdog_d;
      stale_q    <= stale_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    scaler_o = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel_i == SEL_W'(i)) scaler_o = hold_q[i];
    end
  end

  assign valid_o      = valid_q;
  assign overrun_o    = ovr_q;
  assign tick_stale_o = stale_q;

endmodule

// File: tb/tb_scaler_gate_counter.sv
// Bench for scaler_gate_counter: table of gates with expected held counts,
// plus hand sequences for watchdog expiry and reset mid-gate.
`timescale 1ns/1ps
module tb_scaler_gate_counter;

  localparam int NCH = 4, CNT_W = 4, GATE_TICKS = 4, TICK_TIMEOUT = 25, SEL_W = 2;

  logic             clk33_i = 1'b0;
  logic             rst_n_i = 1'b1;
  logic             khz_clk_i = 1'b0;
  logic [NCH-1:0]   hit_i = '0;
  logic [SEL_W-1:0] rd_sel_i = '0;
  logic             rd_ack_i = 1'b0;
  logic [CNT_W-1:0] scaler_o;
  logic             valid_o, overrun_o, tick_stale_o;

  scaler_gate_counter #(
    .NCH(NCH), .CNT_W(CNT_W), .GATE_TICKS(GATE_TICKS),
    .TICK_TIMEOUT(TICK_TIMEOUT), .SEL_W(SEL_W)
  ) dut (
    .clk33_i(clk33_i), .rst_n_i(rst_n_i), .khz_clk_i(khz_clk_i), .hit_i(hit_i),
    .rd_sel_i(rd_sel_i), .rd_ack_i(rd_ack_i), .scaler_o(scaler_o),
    .valid_o(valid_o), .overrun_o(overrun_o), .tick_stale_o(tick_stale_o)
  );

  always #5 clk33_i = ~clk33_i;

  typedef struct {
    logic [NCH-1:0][4:0]       e;
    logic [NCH-1:0]            late;
    bit                        ack_s;
    bit                        ack_e;
    logic [NCH-1:0][CNT_W-1:0] xc;
    bit                        xovr;
  } vec_t;

  typedef struct {
    logic [NCH-1:0][CNT_W-1:0] cnt;
    bit                        ovr;
  } exp_t;

  vec_t vt[9];
  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  bit   valid_m = 1'b0;

  function automatic vec_t mk(int e0, int e1, int e2, int e3, logic [3:0] late,
                              bit ack_s, bit ack_e, int x0, int x1, int x2, int x3, bit xovr);
    vec_t r;
    r.e[0] = 5'(e0); r.e[1] = 5'(e1); r.e[2] = 5'(e2); r.e[3] = 5'(e3);
    r.late = late; r.ack_s = ack_s; r.ack_e = ack_e;
    r.xc[0] = CNT_W'(x0); r.xc[1] = CNT_W'(x1); r.xc[2] = CNT_W'(x2); r.xc[3] = CNT_W'(x3);
    r.xovr = xovr;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk33_i);
    #1;
  endtask

  task automatic drive(input bit tick, input logic [NCH-1:0] h, input bit ack);
    khz_clk_i = tick;
    hit_i     = h;
    rd_ack_i  = ack;
    cyc();
    khz_clk_i = 1'b0;
    rd_ack_i  = 1'b0;
  endtask

  task automatic check_hold(input string tag, input logic [NCH-1:0][CNT_W-1:0] x);
    for (int s = 0; s < NCH; s++) begin
      rd_sel_i = SEL_W'(s);
      #1;
      chk($sformatf("%s_sel%0d", tag, s), 32'(scaler_o), 32'(x[s]));
    end
    rd_sel_i = '0;
  endtask

  // One gate of 40 cycles, ticks every 10 cycles; gate-end tick on the last cycle.
  task automatic run_gate(input vec_t v, input string tag);
    exp_t x;
    logic [NCH-1:0] h;
    x.cnt = v.xc;
    x.ovr = v.xovr;
    sb.push_back(x);
    for (int j = 0; j < 40; j++) begin
      for (int i = 0; i < NCH; i++)
        h[i] = ((j % 2 == 1) && (j / 2 < int'(v.e[i]))) || (j == 39 && v.late[i]);
      drive(j % 10 == 9, h, (j == 0 && v.ack_s) || (j == 39 && v.ack_e));
      if (j == 0 && v.ack_s && valid_m) begin
        valid_m = 1'b0;
        chk({tag, "_ack_valid"}, 32'(valid_o), 0);
        chk({tag, "_ack_ovr"}, 32'(overrun_o), 0);
      end
      if (j == 38) chk({tag, "_pre_valid"}, 32'(valid_o), 32'(valid_m));
    end
    valid_m = 1'b1;
    x = sb.pop_front();
    chk({tag, "_valid"}, 32'(valid_o), 1);
    chk({tag, "_ovr"}, 32'(overrun_o), 32'(x.ovr));
    check_hold(tag, x.cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    vt[0] = mk(7, 0, 0, 0,   4'b0000, 0, 0, 7, 0, 0, 0,   0);
    vt[1] = mk(0, 0, 20, 0,  4'b0000, 1, 0, 0, 0, 15, 0,  0);
    vt[2] = mk(5, 1, 2, 3,   4'b0000, 1, 0, 5, 1, 2, 3,   0);
    vt[3] = mk(9, 0, 0, 0,   4'b0000, 0, 0, 9, 0, 0, 0,   1);
    vt[4] = mk(2, 4, 6, 8,   4'b0000, 1, 0, 2, 4, 6, 8,   0);
    vt[5] = mk(3, 3, 3, 3,   4'b0000, 0, 1, 3, 3, 3, 3,   0);
    vt[6] = mk(1, 0, 0, 16,  4'b0000, 0, 0, 1, 0, 0, 15,  1);
    vt[7] = mk(0, 0, 0, 0,   4'b0010, 1, 0, 0, 1, 0, 0,   0);
    vt[8] = mk(0, 0, 0, 2,   4'b0000, 1, 0, 0, 0, 0, 2,   0);

    #1 rst_n_i = 1'b0;
    #2;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_ovr", 32'(overrun_o), 0);
    chk("rst_stale", 32'(tick_stale_o), 0);
    chk("rst_scaler", 32'(scaler_o), 0);
    cyc();
    cyc();
    rst_n_i = 1'b1;

    // Edges before and during the start tick must not be counted.
    for (int j = 0; j < 10; j++) drive(j == 9, (j % 2 == 1) ? 4'b0001 : 4'b0000, 0);
    chk("start_valid", 32'(valid_o), 0);

    for (int k = 0; k < 9; k++) run_gate(vt[k], $sformatf("v%0d", k));

    // Watchdog: one tick into a gate, then the tick stream stops.
    for (int j = 0; j < 10; j++) begin
      drive(j == 9, (j == 1 || j == 3 || j == 5) ? 4'b1000 : 4'b0000, j == 0);
      if (j == 0) begin
        valid_m = 1'b0;
        chk("wd_ack_valid", 32'(valid_o), 0);
      end
    end
    for (int k = 1; k <= 25; k++) begin
      drive(0, 4'b0000, 0);
      if (k == 24) chk("wd_stale_early", 32'(tick_stale_o), 0);
      if (k == 25) chk("wd_stale_set", 32'(tick_stale_o), 1);
    end
    chk("wd_valid", 32'(valid_o), 0);
    check_hold("wd_hold", {4'd2, 4'd0, 4'd0, 4'd0});
    for (int k = 0; k < 6; k++) drive(0, (k % 2 == 1) ? 4'b1000 : 4'b0000, 0);
    chk("wd_stale_hold", 32'(tick_stale_o), 1);
    drive(0, 4'b0000, 0);
    drive(1, 4'b1000, 0);
    chk("wd_stale_clr", 32'(tick_stale_o), 0);
    run_gate(mk(0, 0, 0, 4, 4'b0000, 0, 0, 0, 0, 0, 4, 0), "wd_resume");
    run_gate(mk(0, 0, 0, 6, 4'b0000, 0, 0, 0, 0, 0, 6, 1), "pre_rst");

    // Reset mid-gate with a valid, overrun held set.
    for (int j = 0; j < 15; j++) drive(j == 9, (j % 2 == 1) ? 4'b0001 : 4'b0000, 0);
    #2 rst_n_i = 1'b0;
    #1;
    chk("mrst_valid", 32'(valid_o), 0);
    chk("mrst_ovr", 32'(overrun_o), 0);
    chk("mrst_stale", 32'(tick_stale_o), 0);
    rd_sel_i = 2'd3;
    #1;
    chk("mrst_scaler", 32'(scaler_o), 0);
    rd_sel_i = '0;
    cyc();
    cyc();
    rst_n_i = 1'b1;
    valid_m = 1'b0;
    for (int j = 0; j < 10; j++) drive(0, (j % 2 == 1) ? 4'b0001 : 4'b0000, 0);
    chk("post_rst_valid", 32'(valid_o), 0);
    drive(1, 4'b0000, 0);
    run_gate(mk(1, 0, 0, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 0), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scaler_gate_counter.md
Name: scaler_gate_counter

Overview:
- Receiving end of the 1 kHz scaler tick produced by the scaler clock generator.
- Counts rising edges on NCH trigger/discriminator lines over a gate of GATE_TICKS tick periods, then latches the totals into holding registers for readout.
- Flags overrun when a result is replaced before it has been read.
- Includes a tick watchdog that discards partial gates when the tick stream stops.

Parameters:
- NCH, 4, number of scaler channels.
- CNT_W, 16, width of each counter; counters saturate at 2^CNT_W-1.
- GATE_TICKS, 1000, khz ticks per gate (1000 = 1 s gate); must be >= 1.
- TICK_TIMEOUT, 40000, clk33 cycles without a tick before the tick is declared stale.
- SEL_W, 2, readout select width; must be >= max(1, clog2(NCH)).

Ports:
- clk33_i, in, 1, 33 MHz system clock.
- rst_n_i, in, 1, reset; asynchronous assert, active-low.
- khz_clk_i, in, 1, one-cycle tick pulse, synchronous to clk33_i.
- hit_i, in, NCH, per-channel scaler inputs, already synchronous to clk33_i.
- rd_sel_i, in, SEL_W, channel select for scaler_o.
- rd_ack_i, in, 1, one-cycle acknowledge that the held set has been read.
- scaler_o, out, CNT_W, held count of channel rd_sel_i; combinational mux of holding registers; 0 if rd_sel_i >= NCH.
- valid_o, out, 1, new held set available and not yet acknowledged.
- overrun_o, out, 1, sticky flag: a held set was overwritten while unacknowledged.
- tick_stale_o, out, 1, no tick seen for TICK_TIMEOUT cycles.

Behaviour:
- Clock and reset: one clock, clk33_i. Reset is rst_n_i, asynchronous and active-low.
- Reset values: all counters, holding registers, hit delay registers, gate tick count and watchdog are 0. valid_o, overrun_o and tick_stale_o are 0. FSM is in WAIT_TICK.
- Edge detect: per channel, edge = hit_i & ~hit_d, where hit_d is the registered hit_i (reset 0).
- FSM states:
  - WAIT_TICK: counting is disabled and counters are held at 0. On khz_clk_i, go to COUNTING with tick_cnt=0. Edges in the start-tick cycle are not counted.
  - COUNTING: on each edge, count[i] += 1, saturating. On khz_clk_i:
    - If tick_cnt == GATE_TICKS-1, this is a gate end. Set hold[i] <= sat(count[i] + edge[i]), so an edge in the gate-end cycle belongs to the ending gate. Clear count[i] and tick_cnt. The next gate begins the following cycle; stay in COUNTING.
    - Otherwise tick_cnt += 1.
  - On tick_stale becoming 1, go to WAIT_TICK, clear counts and tick_cnt, and discard the partial gate. Holding registers are untouched.
- Latency: hold and valid_o update on the clock edge that samples the gate-end tick; both are visible the next cycle.
- Handshake:
  - Gate end sets valid_o=1.
  - rd_ack_i while valid_o=1 clears valid_o and overrun_o next cycle.
  - rd_ack_i while valid_o=0 is ignored.
  - Gate end while valid_o=1 with no ack in the same cycle sets overrun_o=1; hold is overwritten with the new data.
  - Gate end and ack in the same cycle: gate end wins, so valid_o stays 1 and overrun_o ends at 0.
- Watchdog:
  - The counter resets to 0 on each khz_clk_i; otherwise it increments, saturating at TICK_TIMEOUT.
  - tick_stale_o = (watchdog == TICK_TIMEOUT), registered.
  - tick_stale_o clears the cycle after the next tick. That tick is the WAIT_TICK start tick.
- Reset mid-gate: all outputs return to reset values immediately. The first tick after reset release starts a fresh gate.

Test Plan (benches may override parameters as stated):
- GATE_TICKS=4, tick every 10 cycles, 7 rising edges on hit_i[0] within the first gate -> after the 4th tick following the start tick, valid_o=1, scaler_o=7 at sel 0, 0 at sel 1..3. Edges before the start tick are not counted.
- CNT_W=4, 20 edges on hit_i[2] in one gate -> scaler_o=15 at sel 2. An edge coincident with the gate-end tick is included in the ending gate, not in the next one.
- No ack across two gates (5 edges, then 9 edges) -> overrun_o=1 and scaler_o=9. rd_ack_i pulse -> valid_o=0 and overrun_o=0 next cycle.
- rd_ack_i asserted in the same cycle as a gate-end tick while valid_o=1 -> valid_o stays 1, overrun_o=0, and hold shows the new gate.
- TICK_TIMEOUT=25, ticks stop mid-gate with 3 edges counted:
  - tick_stale_o=1 at 25 cycles after the last tick; the partial gate is discarded and hold is unchanged.
  - Ticks resume: tick_stale_o=0 one cycle after the first tick, and the next valid_o comes GATE_TICKS ticks after that tick.
- rst_n_i pulsed low mid-gate with valid_o=1 -> valid_o, overrun_o, tick_stale_o and scaler_o are 0 without waiting for a clock edge. After release, no counting occurs until the first tick.
